exe_issue_fsm: RTL and testbench
================================

// Module: exe_issue_fsm
// PURPOSE
//  Next-generation execution control unit: queues decoded instructions in a DEPTH-entry issue queue,
//  issues them one at a time to the LANES-wide vector ALU, and performs writeback of ALU results.
//  Resolves branches and flushes the queue on a taken branch.
//  Sits between the instruction decoder (valid/ready handshake) and ALU/RAM write port (no tri-state bus).
// PARAMETERS
//  WIDTH      32   bits per ALU lane
//  LANES      3    vector lanes (X,Y,Z); source/result rows are LANES*WIDTH bits
//  OP_W       6    opcode width
//  ADDR_W     16   data RAM address width
//  ROM_W      16   instruction ROM address width (ROM_W <= ADDR_W)
//  DEPTH      2    issue-queue entries (power of 2, >=2)
//  TIMEOUT    255  max cycles waiting for ALU result before error
// PORTS
//  Clock             in   1              clock, all state on rising edge
//  Reset             in   1              asynchronous, active-low reset
//  iDecodeValid      in   1              decoder presents an instruction
//  oDecodeReady      out  1              queue accepts; transfer = iDecodeValid & oDecodeReady
//  iOperation        in   OP_W           opcode
//  iSource0,iSource1 in   LANES*WIDTH    operand rows, lane 0 in MSBs
//  iDestination      in   ADDR_W         writeback address / jump target
//  oALUOperation     out  OP_W           issued opcode (registered)
//  oALUSrcA,oALUSrcB out  LANES*WIDTH    issued iSource1 / iSource0 rows (registered)
//  oTriggerALU       out  1              one-cycle start pulse
//  iALUResult        in   LANES*WIDTH    ALU result row
//  iALUOutputReady   in   1              result valid (one cycle)
//  iBranchTaken      in   1              qualified by iALUOutputReady
//  iBranchNotTaken   in   1              qualified by iALUOutputReady
//  oJumpFlag         out  1              taken-branch pulse to fetch
//  oJumpIp           out  ROM_W          low ROM_W bits of issued destination
//  oRAMWriteEnable   out  1              writeback strobe
//  oRAMWriteAddress  out  ADDR_W         issued destination (registered)
//  oRAMWriteData     out  LANES*WIDTH    = iALUResult
//  oLastDestination  out  ADDR_W         = oRAMWriteAddress, for data forwarding
//  oQueueCount       out  clog2(DEPTH)+1 occupied entries
//  oBusy             out  1              state!=IDLE or queue non-empty
//  oError            out  1              sticky ALU-timeout flag, cleared only by reset
// BEHAVIOUR
//  Reset: state IDLE; queue empty; all registered outputs 0; oTriggerALU=0; oError=0; timer=0.
//  Queue: push when iDecodeValid & oDecodeReady. oDecodeReady = (count<DEPTH) & state!=FLUSH.
//   A full queue does not accept, even in a pop cycle. Pointers wrap modulo DEPTH.
//  FSM states IDLE, WAIT_ALU, FLUSH:
//   IDLE: if count>0, capture head into issue registers, pop, set oTriggerALU=1 for the next cycle,
//    clear timer, go WAIT_ALU.
//   WAIT_ALU: oTriggerALU is high only in the first cycle. Timer increments while !iALUOutputReady.
//    iALUOutputReady & iBranchTaken: oJumpFlag=1 that cycle (combinational), no write, go FLUSH.
//    iALUOutputReady otherwise: write per the rule below. If count>0, capture/pop the next head
//     back-to-back (re-pulse trigger, stay WAIT_ALU); else go IDLE.
//    Timer==TIMEOUT with no result: set oError, drop the instruction, go IDLE.
//   FLUSH: one cycle; empties the queue (including any entry pushed in the branch cycle);
//    oDecodeReady=0; go IDLE.
//  oRAMWriteEnable = state==WAIT_ALU & iALUOutputReady & !iBranchTaken & !iBranchNotTaken
//   & op!=NOP & op!=DEBUG_PRINT.
//  iALUOutputReady outside WAIT_ALU is ignored: no write, no jump.
//  Latency: accept at edge 0 into an empty, idle unit -> trigger high in cycle 2.
//   Back-to-back issue: trigger is high the cycle after the result.
//  Reset mid-operation: all of the above returns to reset values asynchronously.
//   In-flight ALU result is discarded.
// STRUCTURE
//  Shared package exe_pkg: state encodings, NOP/DEBUG_PRINT opcodes, lane-slice macros, clog2 function.
//  Sub-module exe_issue_queue: DEPTH x (OP_W+ADDR_W+2*LANES*WIDTH) FIFO with count/full/empty.
//  FSM, timer and issue registers live in exe_issue_fsm.
// TESTING
//  1 ADD dst=0x0010, src rows 1/2, ALU ready 3 cycles after trigger -> one write to 0x0010,
//    oRAMWriteData=result, oBusy falls the cycle after.
//  2 Push 3 ops with DEPTH=2 and ALU stalled -> oDecodeReady low after 2nd; 3rd accepted once a pop
//    occurs; all 3 written in order, no gap between results and next trigger.
//  3 JMP dst=0x0042 with BranchTaken, 1 op queued plus 1 pushed in the same cycle -> oJumpFlag=1,
//    oJumpIp=0x0042, no write, FLUSH empties queue, count=0.
//  4 NOP, then DEBUG_PRINT, then BranchNotTaken op -> three results, oRAMWriteEnable never asserted.
//  5 ALU never answers, TIMEOUT=8 -> oError set 8 cycles after trigger, state IDLE, next op issues.
//  6 Reset low while WAIT_ALU with 2 queued -> outputs 0 immediately; late iALUOutputReady ignored.

Source files
------------

// File: rtl/exe_pkg.sv
// exe_pkg: shared state encoding, opcodes and sizing helpers for the execution unit
package exe_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ALU = 2'd1,
    FLUSH    = 2'd2
  } state_t;
  localparam logic [5:0] OP_NOP         = 6'h00;
  localparam logic [5:0] OP_DEBUG_PRINT = 6'h3f;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; (1 << i) < v; i++) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/exe_issue_queue.sv
// exe_issue_queue: DEPTH-entry FIFO holding decoded instructions awaiting issue
module exe_issue_queue
  import exe_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 2,
  localparam int AW   = clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  assign dout  = mem[rd_ptr];
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
  // pointers wrap naturally since DEPTH is a power of two; flush discards everything
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  // entry storage needs no reset; occupancy is tracked by count
  always_ff @(posedge Clock)
    if (push) mem[wr_ptr] <= din;
endmodule

// File: rtl/exe_issue_fsm.sv
// exe_issue_fsm: queues decoded instructions, issues them to the vector ALU and writes results back
module exe_issue_fsm
  import exe_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LANES   = 3,
  parameter int OP_W    = 6,
  parameter int ADDR_W  = 16,
  parameter int ROM_W   = 16,
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 255,
  localparam int RW     = LANES * WIDTH,
  localparam int CW     = clog2(DEPTH) + 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iDecodeValid,
  output logic              oDecodeReady,
  input  logic [OP_W-1:0]   iOperation,
  input  logic [RW-1:0]     iSource0,
  input  logic [RW-1:0]     iSource1,
  input  logic [ADDR_W-1:0] iDestination,
  output logic [OP_W-1:0]   oALUOperation,
  output logic [RW-1:0]     oALUSrcA,
  output logic [RW-1:0]     oALUSrcB,
  output logic              oTriggerALU,
  input  logic [RW-1:0]     iALUResult,
  input  logic              iALUOutputReady,
  input  logic              iBranchTaken,
  input  logic              iBranchNotTaken,
  output logic              oJumpFlag,
  output logic [ROM_W-1:0]  oJumpIp,
  output logic              oRAMWriteEnable,
  output logic [ADDR_W-1:0] oRAMWriteAddress,
  output logic [RW-1:0]     oRAMWriteData,
  output logic [ADDR_W-1:0] oLastDestination,
  output logic [CW-1:0]     oQueueCount,
  output logic              oBusy,
  output logic              oError
);
  localparam int QW = OP_W + ADDR_W + 2 * RW;
  localparam int TW = clog2(TIMEOUT + 1);
  state_t            state;
  state_t            state_nxt;
  logic              issue;
  logic              timeout;
  logic              q_push;
  logic              q_flush;
  logic              q_full;
  logic              q_empty;
  logic [QW-1:0]     q_dout;
  logic [OP_W-1:0]   h_op;
  logic [ADDR_W-1:0] h_dst;
  logic [RW-1:0]     h_s0;
  logic [RW-1:0]     h_s1;
  logic [OP_W-1:0]   op_q;
  logic [ADDR_W-1:0] dst_q;
  logic [TW-1:0]     timer;
  assign oDecodeReady = !q_full && state != FLUSH;
  assign q_push = iDecodeValid && oDecodeReady;
  assign {h_op, h_dst, h_s1, h_s0} = q_dout;
  assign oALUOperation = op_q;
  assign oRAMWriteAddress = dst_q;
  assign oLastDestination = dst_q;
  assign oJumpIp = dst_q[ROM_W-1:0];
  assign oRAMWriteData = iALUResult;
  assign oBusy = state != IDLE || !q_empty;
  exe_issue_queue #(.W(QW), .DEPTH(DEPTH)) u_queue (
    .Clock (Clock),
    .Reset (Reset),
    .push  (q_push),
    .pop   (issue),
    .flush (q_flush),
    .din   ({iOperation, iDestination, iSource1, iSource0}),
    .dout  (q_dout),
    .count (oQueueCount),
    .full  (q_full),
    .empty (q_empty)
  );
  // next state, issue decision, writeback/jump strobes; a result in the same cycle as the timeout wins
  always_comb begin
    state_nxt = state;
    issue = 1'b0;
    timeout = 1'b0;
    oJumpFlag = 1'b0;
    oRAMWriteEnable = 1'b0;
    q_flush = 1'b0;
    case (state)
      IDLE: begin
        issue = !q_empty;
        state_nxt = q_empty ? IDLE : WAIT_ALU;
      end
      WAIT_ALU:
        if (iALUOutputReady && iBranchTaken) begin
          oJumpFlag = 1'b1;
          state_nxt = FLUSH;
        end else if (iALUOutputReady) begin
          oRAMWriteEnable = !iBranchNotTaken && op_q != OP_W'(OP_NOP) && op_q != OP_W'(OP_DEBUG_PRINT);
          issue = !q_empty;
          state_nxt = q_empty ? IDLE : WAIT_ALU;
        end else if (timer == TW'(TIMEOUT)) begin
          timeout = 1'b1;
          state_nxt = IDLE;
        end
      FLUSH: begin
        q_flush = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) state <= IDLE;
    else state <= state_nxt;
  // issue registers, one-cycle trigger, result timer and sticky timeout flag
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) begin
      op_q <= '0;
      dst_q <= '0;
      oALUSrcA <= '0;
      oALUSrcB <= '0;
      oTriggerALU <= 1'b0;
      timer <= '0;
      oError <= 1'b0;
    end else begin
      oTriggerALU <= issue;
      if (issue) begin
        op_q <= h_op;
        dst_q <= h_dst;
        oALUSrcA <= h_s1;
        oALUSrcB <= h_s0;
        timer <= '0;
      end else if (state == WAIT_ALU && !iALUOutputReady && !timeout) timer <= timer + TW'(1);
      if (timeout) oError <= 1'b1;
    end
endmodule

// File: tb/tb_exe_issue_fsm.sv
// tb_exe_issue_fsm: directed scenarios plus randomized traffic against a transaction-level model
module tb_exe_issue_fsm;
  localparam int WIDTH = 32, LANES = 3, OP_W = 6, ADDR_W = 16, ROM_W = 16, DEPTH = 2, TIMEOUT = 8;
  localparam int RW = LANES * WIDTH;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [OP_W-1:0] NOP = 6'h00, DBG = 6'h3f, ADD = 6'h01, JMP = 6'h20;

  logic Clock, Reset;
  logic iDecodeValid, oDecodeReady;
  logic [OP_W-1:0] iOperation, oALUOperation;
  logic [RW-1:0] iSource0, iSource1, oALUSrcA, oALUSrcB, iALUResult, oRAMWriteData;
  logic [ADDR_W-1:0] iDestination, oRAMWriteAddress, oLastDestination;
  logic oTriggerALU, iALUOutputReady, iBranchTaken, iBranchNotTaken, oJumpFlag;
  logic [ROM_W-1:0] oJumpIp;
  logic oRAMWriteEnable, oBusy, oError;
  logic [CW-1:0] oQueueCount;

  exe_issue_fsm #(.WIDTH(WIDTH), .LANES(LANES), .OP_W(OP_W), .ADDR_W(ADDR_W), .ROM_W(ROM_W),
                  .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .Clock(Clock), .Reset(Reset), .iDecodeValid(iDecodeValid), .oDecodeReady(oDecodeReady),
    .iOperation(iOperation), .iSource0(iSource0), .iSource1(iSource1), .iDestination(iDestination),
    .oALUOperation(oALUOperation), .oALUSrcA(oALUSrcA), .oALUSrcB(oALUSrcB), .oTriggerALU(oTriggerALU),
    .iALUResult(iALUResult), .iALUOutputReady(iALUOutputReady), .iBranchTaken(iBranchTaken),
    .iBranchNotTaken(iBranchNotTaken), .oJumpFlag(oJumpFlag), .oJumpIp(oJumpIp),
    .oRAMWriteEnable(oRAMWriteEnable), .oRAMWriteAddress(oRAMWriteAddress), .oRAMWriteData(oRAMWriteData),
    .oLastDestination(oLastDestination), .oQueueCount(oQueueCount), .oBusy(oBusy), .oError(oError)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_vec = 0, n_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // transaction-level model: a list of pending instructions and the one the ALU is working on
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] dst;
    logic [RW-1:0]     s0;
    logic [RW-1:0]     s1;
  } ins_t;
  ins_t q[$];
  ins_t cur;
  bit   in_alu, flushing, trig, err;
  int   waited;

  function automatic void model_reset();
    q.delete();
    cur = '0;
    in_alu = 0;
    flushing = 0;
    trig = 0;
    err = 0;
    waited = 0;
  endfunction

  task automatic check_all();
    bit res = iALUOutputReady && in_alu;
    chk("ready", oDecodeReady, q.size() < DEPTH && !flushing);
    chk("trigger", oTriggerALU, trig);
    chk("alu_op", oALUOperation, cur.op);
    chk("srcA", oALUSrcA, cur.s1);
    chk("srcB", oALUSrcB, cur.s0);
    chk("waddr", oRAMWriteAddress, cur.dst);
    chk("lastdst", oLastDestination, cur.dst);
    chk("jump_ip", oJumpIp, cur.dst[ROM_W-1:0]);
    chk("jump", oJumpFlag, res && iBranchTaken);
    chk("we", oRAMWriteEnable, res && !iBranchTaken && !iBranchNotTaken && cur.op != NOP && cur.op != DBG);
    chk("wdata", oRAMWriteData, iALUResult);
    chk("count", oQueueCount, q.size());
    chk("busy", oBusy, in_alu || flushing || q.size() != 0);
    chk("error", oError, err);
  endtask

  function automatic void model_step();
    bit   push = iDecodeValid && q.size() < DEPTH && !flushing;
    bit   may_issue = 0;
    ins_t n;
    n.op = iOperation;
    n.dst = iDestination;
    n.s0 = iSource0;
    n.s1 = iSource1;
    trig = 0;
    if (flushing) begin
      q.delete();
      flushing = 0;
    end else if (in_alu) begin
      if (iALUOutputReady) begin
        in_alu = 0;
        if (iBranchTaken) flushing = 1;
        else may_issue = 1;
      end else if (waited == TIMEOUT) begin
        err = 1;
        in_alu = 0;
      end else waited++;
    end else may_issue = 1;
    if (may_issue && q.size() > 0) begin
      cur = q.pop_front();
      in_alu = 1;
      waited = 0;
      trig = 1;
    end
    if (push) q.push_back(n);
  endfunction

  // check the cycle at the falling edge, then advance the model past the rising edge
  task automatic tick();
    @(negedge Clock);
    check_all();
    @(posedge Clock);
    model_step();
    #1;
  endtask

  task automatic dec(input bit v, input logic [OP_W-1:0] op, input logic [ADDR_W-1:0] d);
    iDecodeValid = v;
    iOperation = op;
    iDestination = d;
    iSource0 = {$urandom(), $urandom(), $urandom()};
    iSource1 = {$urandom(), $urandom(), $urandom()};
  endtask

  task automatic alu(input bit r, input bit t, input bit nt, input logic [RW-1:0] res);
    iALUOutputReady = r;
    iBranchTaken = t;
    iBranchNotTaken = nt;
    iALUResult = res;
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_trig"}, oTriggerALU, 0);
    chk({tag, "_op"}, oALUOperation, 0);
    chk({tag, "_srcA"}, oALUSrcA, 0);
    chk({tag, "_srcB"}, oALUSrcB, 0);
    chk({tag, "_waddr"}, oRAMWriteAddress, 0);
    chk({tag, "_count"}, oQueueCount, 0);
    chk({tag, "_busy"}, oBusy, 0);
    chk({tag, "_error"}, oError, 0);
    chk({tag, "_jump"}, oJumpFlag, 0);
    chk({tag, "_we"}, oRAMWriteEnable, 0);
    chk({tag, "_ready"}, oDecodeReady, 1);
  endtask

  // asserted mid-cycle: outputs must clear without waiting for a clock edge
  task automatic do_reset(input string tag);
    #2 Reset = 1'b0;
    #1 rst_chk(tag);
    model_reset();
    @(posedge Clock);
    #1 Reset = 1'b1;
  endtask

  function automatic logic [OP_W-1:0] rand_op();
    int r = $urandom_range(0, 19);
    return r < 5 ? NOP : r < 8 ? DBG : r < 10 ? JMP : OP_W'($urandom_range(1, 62));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  localparam logic [RW-1:0] RES1 = 96'hDEAD_BEEF_0123_4567_89AB_CDEF;

  initial begin
    Reset = 1'b1;
    dec(0, NOP, '0);
    alu(0, 0, 0, '0);
    model_reset();
    #1 Reset = 1'b0;
    #1 rst_chk("reset");
    @(posedge Clock);
    #1 Reset = 1'b1;

    // 1: single ADD, result 3 cycles after trigger
    dec(1, ADD, 16'h0010);
    iSource0 = 96'h1;
    iSource1 = 96'h2;
    tick();
    dec(0, NOP, '0);
    #1 chk("t1_trig_c1", oTriggerALU, 0);
    chk("t1_count_c1", oQueueCount, 1);
    tick();
    #1 chk("t1_trig_c2", oTriggerALU, 1);
    chk("t1_srcA", oALUSrcA, 96'h2);
    chk("t1_srcB", oALUSrcB, 96'h1);
    tick();
    tick();
    tick();
    alu(1, 0, 0, RES1);
    #1 chk("t1_we", oRAMWriteEnable, 1);
    chk("t1_waddr", oRAMWriteAddress, 16'h0010);
    chk("t1_wdata", oRAMWriteData, RES1);
    chk("t1_busy_result", oBusy, 1);
    tick();
    alu(0, 0, 0, '0);
    #1 chk("t1_busy_after", oBusy, 0);

    // 2: queue fills while ALU stalls; full queue refuses even on a pop
    dec(1, ADD, 16'h0100); tick();
    dec(1, ADD, 16'h0101); tick();
    dec(1, ADD, 16'h0102); tick();
    dec(1, ADD, 16'h0103);
    #1 chk("t2_full_ready", oDecodeReady, 0);
    chk("t2_full_count", oQueueCount, 2);
    tick();
    tick();
    alu(1, 0, 0, RES1);
    #1 chk("t2_pop_ready", oDecodeReady, 0);
    chk("t2_we_a", oRAMWriteEnable, 1);
    chk("t2_addr_a", oRAMWriteAddress, 16'h0100);
    tick();
    alu(0, 0, 0, '0);
    #1 chk("t2_b2b_trig", oTriggerALU, 1);
    chk("t2_b2b_addr", oRAMWriteAddress, 16'h0101);
    chk("t2_d_ready", oDecodeReady, 1);
    tick();
    dec(0, NOP, '0);
    alu(1, 0, 0, RES1);
    repeat (3) tick();
    alu(0, 0, 0, '0);
    #1 chk("t2_drained", oBusy, 0);

    // 3: taken branch flushes queued and same-cycle pushed entries
    dec(1, JMP, 16'h0042); tick();
    dec(1, ADD, 16'h0200); tick();
    dec(1, ADD, 16'h0201);
    alu(1, 1, 0, '0);
    #1 chk("t3_jump", oJumpFlag, 1);
    chk("t3_jip", oJumpIp, 16'h0042);
    chk("t3_we", oRAMWriteEnable, 0);
    tick();
    dec(0, NOP, '0);
    alu(0, 0, 0, '0);
    #1 chk("t3_flush_ready", oDecodeReady, 0);
    tick();
    #1 chk("t3_count", oQueueCount, 0);
    chk("t3_busy", oBusy, 0);

    // 4: NOP, DEBUG_PRINT and a not-taken branch never write
    dec(1, NOP, 16'h0300); tick();
    dec(1, DBG, 16'h0301); tick();
    dec(1, ADD, 16'h0302); tick();
    dec(0, NOP, '0);
    for (int i = 0; i < 6; i++) begin
      alu(1, 0, cur.op == ADD, RES1);
      #1 chk("t4_we", oRAMWriteEnable, 0);
      tick();
    end
    alu(0, 0, 0, '0);
    #1 chk("t4_idle", oBusy, 0);

    // 5: ALU never answers; timeout drops the op and the next one issues
    dec(1, ADD, 16'h0400); tick();
    dec(0, NOP, '0); tick();
    dec(1, ADD, 16'h0401); tick();
    dec(0, NOP, '0);
    repeat (TIMEOUT - 1) tick();
    #1 chk("t5_err_before", oError, 0);
    chk("t5_busy", oBusy, 1);
    tick();
    #1 chk("t5_err_set", oError, 1);
    chk("t5_no_trig", oTriggerALU, 0);
    tick();
    #1 chk("t5_next_trig", oTriggerALU, 1);
    chk("t5_next_addr", oRAMWriteAddress, 16'h0401);
    alu(1, 0, 0, RES1);
    tick();
    alu(0, 0, 0, '0);
    tick();

    // 6: reset while waiting with two queued; a late result must be ignored
    dec(1, ADD, 16'h0500); tick();
    dec(1, ADD, 16'h0501); tick();
    dec(1, ADD, 16'h0502); tick();
    dec(0, NOP, '0);
    tick();
    alu(1, 1, 0, RES1);
    do_reset("t6");
    tick();
    alu(0, 0, 0, '0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset("rnd_rst");
      dec($urandom_range(0, 9) < 6, rand_op(), ADDR_W'($urandom()));
      alu($urandom_range(0, 9) < 4, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
          {$urandom(), $urandom(), $urandom()});
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
